// File: rtl/bch_decoder.sv
// Serial SEC-DED decoder for the (63,56) code with g(x)=x^7+x^6+x^2+1.
// It computes the syndrome bit-serially, then searches x^j mod g(x) to locate a single error.
module bch_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [62:0] cw_in,
  output logic        busy,
  output logic        valid,
  output logic [55:0] data_out,
  output logic        err_corr,
  output logic        err_uncorr,
  output logic [5:0]  err_pos
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYND   = 3'd1,
    CHECK  = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [62:0] sr;
  logic [6:0]  s;
  logic [6:0]  r;
  logic [5:0]  cnt;
  logic [55:0] fixed_data;

  function automatic logic [6:0] synd_step(input logic [6:0] s_in, input logic b);
    logic [7:0] t;
    t = {s_in, b};
    if (t[7]) begin
      t = t ^ 8'hC5;
    end else begin
      t = t;
    end
    return t[6:0];
  endfunction

  // Multiply by x modulo g(x); x^7 reduces to x^6+x^2+1.
  function automatic logic [6:0] alpha_step(input logic [6:0] r_in);
    return {r_in[5:0], 1'b0} ^ (r_in[6] ? 7'h45 : 7'h00);
  endfunction

  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

  // Data field with bit cnt flipped; errors in parity positions leave data intact.
  always_comb begin
    fixed_data = sr[62:7];
    if (cnt >= 6'd7) begin
      fixed_data = sr[62:7] ^ (56'd1 << (cnt - 6'd7));
    end else begin
      fixed_data = sr[62:7];
    end
  end

  // Decoder FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= 63'd0;
      s          <= 7'd0;
      r          <= 7'd0;
      cnt        <= 6'd0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      data_out   <= 56'd0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_pos    <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            sr    <= cw_in;
            s     <= 7'd0;
            r     <= 7'd0;
            cnt   <= 6'd0;
            busy  <= 1'b1;
            state <= SYND;
          end else begin
            busy  <= 1'b0;
          end
        end
        // Rotating the register leaves the original codeword in place after 63 steps.
        SYND: begin
          if (cnt == 6'd63) begin
            cnt   <= 6'd0;
            state <= CHECK;
          end else begin
            s   <= synd_step(s, sr[62]);
            sr  <= {sr[61:0], sr[62]};
            cnt <= cnt + 6'd1;
          end
        end
        CHECK: begin
          if (s == 7'd0) begin
            data_out   <= sr[62:7];
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            err_pos    <= 6'd0;
            valid      <= 1'b1;
            state      <= DONE;
          end else if (!parity7(s)) begin
            data_out   <= sr[62:7];
            err_corr   <= 1'b0;
            err_uncorr <= 1'b1;
            err_pos    <= 6'd0;
            valid      <= 1'b1;
            state      <= DONE;
          end else begin
            r     <= 7'h01;
            cnt   <= 6'd0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (r == s) begin
            data_out   <= fixed_data;
            err_corr   <= 1'b1;
            err_uncorr <= 1'b0;
            err_pos    <= cnt;
            valid      <= 1'b1;
            state      <= DONE;
          end else if (cnt == 6'd62) begin
            data_out   <= sr[62:7];
            err_corr   <= 1'b0;
            err_uncorr <= 1'b1;
            err_pos    <= 6'd0;
            valid      <= 1'b1;
            state      <= DONE;
          end else begin
            r   <= alpha_step(r);
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_decoder.sv
// Scoreboard bench for bch_decoder: directed codewords push expectations,
// and a negedge monitor checks every valid pulse, including its cycle of arrival.
module tb_bch_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [62:0] cw_in = 63'd0;
  logic        busy;
  logic        valid;
  logic [55:0] data_out;
  logic        err_corr;
  logic        err_uncorr;
  logic [5:0]  err_pos;

  typedef struct {
    string       name;
    logic [55:0] data;
    logic        corr;
    logic        uncorr;
    logic [5:0]  pos;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [55:0] D1 = 56'h555555DDDDDDDD;
  localparam logic [55:0] D2 = 56'hA0123456789ABC;

  bch_decoder dut (
    .clk(clk), .rst(rst), .start(start), .cw_in(cw_in),
    .busy(busy), .valid(valid), .data_out(data_out),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .err_pos(err_pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Systematic encoder: parity is (d * x^7) mod g(x) by long division.
  function automatic logic [62:0] encode(input logic [55:0] d);
    logic [62:0] m;
    m = {d, 7'd0};
    for (int i = 62; i >= 7; i--) begin
      if (m[i]) m = m ^ (63'(8'hC5) << (i - 7));
    end
    return {d, m[6:0]};
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"},   64'(data_out),   64'(e.data));
        chk({e.name, "_corr"},   64'(err_corr),   64'(e.corr));
        chk({e.name, "_uncorr"}, 64'(err_uncorr), 64'(e.uncorr));
        chk({e.name, "_pos"},    64'(err_pos),    64'(e.pos));
        chk({e.name, "_cycle"},  64'(cyc),        64'(e.due));
      end
    end
  end

  task automatic decode(input string nm, input logic [62:0] cw, input logic [55:0] d,
                        input logic corr, input logic uncorr, input logic [5:0] pos,
                        input int lat, input bit poke);
    exp_t e;
    @(negedge clk);
    cw_in = cw;
    start = 1'b1;
    e.name = nm; e.data = d; e.corr = corr; e.uncorr = uncorr; e.pos = pos;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cw_in = ~cw;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    if (poke) begin
      repeat (20) @(negedge clk);
      cw_in = 63'h1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk({nm, "_hold"}, 64'(data_out), 64'(d));
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [62:0] c1;
    logic [62:0] c2;
    c1 = encode(D1);
    c2 = encode(D2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_flags", 64'({err_corr, err_uncorr}), 64'd0);
    chk("rst_pos", 64'(err_pos), 64'd0);

    decode("zero",     63'd0,          56'd0, 1'b0, 1'b0, 6'd0,  65,  1'b0);
    decode("bit0",     63'h1,          56'd0, 1'b1, 1'b0, 6'd0,  66,  1'b0);
    decode("bit62",    63'd1 << 62,    56'd0, 1'b1, 1'b0, 6'd62, 128, 1'b0);
    decode("even",     63'h3,          56'd0, 1'b0, 1'b1, 6'd0,  65,  1'b0);
    decode("exhaust",  63'h43,         56'd0, 1'b0, 1'b1, 6'd0,  128, 1'b0);
    decode("team_b30", c1 ^ (63'd1 << 30), D1, 1'b1, 1'b0, 6'd30, 96, 1'b1);
    decode("clean",    c2,             D2,    1'b0, 1'b0, 6'd0,  65,  1'b0);
    decode("b7",       c2 ^ (63'd1 << 7), D2, 1'b1, 1'b0, 6'd7,  73,  1'b0);
    decode("b6",       c2 ^ (63'd1 << 6), D2, 1'b1, 1'b0, 6'd6,  72,  1'b0);
    decode("double",   c1 ^ (63'd1 << 10) ^ (63'd1 << 50),
           D1 ^ (56'd1 << 3) ^ (56'd1 << 43), 1'b0, 1'b1, 6'd0, 65, 1'b0);

    // Abort in the 40th SYND cycle, with start held high alongside reset.
    @(negedge clk);
    cw_in = 63'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", 64'(data_out), 64'd0);
    chk("abort_flags", 64'({valid, err_corr, err_uncorr}), 64'd0);
    chk("abort_pos", 64'(err_pos), 64'd0);
    repeat (100) @(negedge clk);
    decode("after_rst", c1 ^ (63'd1 << 62), D1, 1'b1, 1'b0, 6'd62, 128, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
